// File: rtl/regfile_dump_ctrl_if.sv
// Valid/ready stream carrying register-file words out of regfile_dump_ctrl.
// The master drives the word; the slave returns ready.
interface regfile_dump_ctrl_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
  modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Post-run register-file readout: waits for END_PC, freezes the core and streams
// registers FIRST_REG..LAST_REG over a valid/ready link; a watchdog flags hangs.
module regfile_dump_ctrl #(
  parameter logic [31:0] END_PC         = 32'h48,
  parameter logic [4:0]  FIRST_REG      = 5'd0,
  parameter logic [4:0]  LAST_REG       = 5'd31,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_current,
  output logic [4:0]           ra3,
  input  logic [31:0]          rd3,
  output logic                 cpu_hold,
  regfile_dump_ctrl_if.master  dump,
  output logic                 done,
  output logic                 timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {WAIT_END, READ, SEND, FINISH, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ra3_q, ra3_d;
  logic          valid_q, valid_d;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          to_q, to_d;
  logic          hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WAIT_END;
      cnt_q   <= '0;
      ra3_q   <= FIRST_REG;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra3_q   <= ra3_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra3_d   = ra3_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = done_q;
    to_d    = to_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_END: begin
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        // PC match takes priority over an expiring watchdog in the same cycle.
        if (pc_current == END_PC) begin
          state_d = READ;
          hold_d  = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = TIMEOUT;
          to_d    = 1'b1;
          done_d  = 1'b1;
          hold_d  = 1'b1;
        end
      end
      READ: begin
        data_d  = rd3;
        idx_d   = ra3_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dump.dump_ready) begin
          valid_d = 1'b0;
          if (ra3_q == LAST_REG) begin
            state_d = FINISH;
          end else begin
            ra3_d   = ra3_q + 5'd1;
            state_d = READ;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        hold_d  = 1'b1;
        valid_d = 1'b0;
      end
      TIMEOUT: begin
        done_d  = 1'b1;
        to_d    = 1'b1;
        hold_d  = 1'b1;
        valid_d = 1'b0;
      end
      default: state_d = WAIT_END;
    endcase
  end

  assign ra3            = ra3_q;
  assign cpu_hold       = hold_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;
  assign done           = done_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: three parameterisations share stimulus; one is
// observed at a time and checked against an expected word list and latency rules.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] regs [32];
  int          sel;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  regfile_dump_ctrl_if if_a ();
  regfile_dump_ctrl_if if_t ();
  regfile_dump_ctrl_if if_s ();
  assign if_a.dump_ready = ready;
  assign if_t.dump_ready = ready;
  assign if_s.dump_ready = ready;

  logic [4:0] ra3_a, ra3_t, ra3_s;
  logic hold_a, hold_t, hold_s, done_a, done_t, done_s, to_a, to_t, to_s;

  regfile_dump_ctrl #(.TIMEOUT_CYCLES(1024)) dut_a (
    .clk(clk), .rst(rst), .pc_current(pc), .ra3(ra3_a), .rd3(regs[ra3_a]),
    .cpu_hold(hold_a), .dump(if_a), .done(done_a), .timeout(to_a));
  regfile_dump_ctrl #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst(rst), .pc_current(pc), .ra3(ra3_t), .rd3(regs[ra3_t]),
    .cpu_hold(hold_t), .dump(if_t), .done(done_t), .timeout(to_t));
  regfile_dump_ctrl #(.FIRST_REG(5'd5), .LAST_REG(5'd5)) dut_s (
    .clk(clk), .rst(rst), .pc_current(pc), .ra3(ra3_s), .rd3(regs[ra3_s]),
    .cpu_hold(hold_s), .dump(if_s), .done(done_s), .timeout(to_s));

  logic [4:0]  o_ra3, o_idx;
  logic [31:0] o_data;
  logic        o_hold, o_valid, o_done, o_timeout;

  always_comb begin
    o_ra3 = ra3_a; o_hold = hold_a; o_valid = if_a.dump_valid; o_idx = if_a.dump_idx;
    o_data = if_a.dump_data; o_done = done_a; o_timeout = to_a;
    if (sel == 1) begin
      o_ra3 = ra3_t; o_hold = hold_t; o_valid = if_t.dump_valid; o_idx = if_t.dump_idx;
      o_data = if_t.dump_data; o_done = done_t; o_timeout = to_t;
    end else if (sel == 2) begin
      o_ra3 = ra3_s; o_hold = hold_s; o_valid = if_s.dump_valid; o_idx = if_s.dump_idx;
      o_data = if_s.dump_data; o_done = done_s; o_timeout = to_s;
    end
  end

  function automatic int first_of(input int s);
    return (s == 2) ? 5 : 0;
  endfunction

  function automatic int last_of(input int s);
    return (s == 2) ? 5 : 31;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ready = 1'b0; pc = '0;
    tick();
    chk("rst_ra3", o_ra3, first_of(sel));
    chk("rst_valid", o_valid, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_done, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_hold", o_hold, 0);
    rst = 1'b1;
  endtask

  task automatic run_to_match();
    for (int k = 0; k <= 18; k++) begin
      pc = 32'(4 * k);
      tick();
      if (k < 18) chk("pre_match_hold", o_hold, 0);
    end
    pc = '0;
  endtask

  // mode 0: ready always 1, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_dump(input int mode, input int stop_idx, output bit stopped);
    int first, last, n, got, cyc;
    logic [4:0]  eidx [32];
    logic [31:0] edata [32];
    logic        pv;
    logic [4:0]  pidx;
    logic [31:0] pdata;
    first = first_of(sel); last = last_of(sel);
    n = last - first + 1; got = 0; cyc = 0; stopped = 1'b0;
    for (int i = 0; i < n; i++) begin
      eidx[i]  = 5'(first + i);
      edata[i] = regs[first + i];
    end
    chk("match_hold", o_hold, 1);
    chk("match_valid", o_valid, 0);
    while (!o_done && cyc < 400) begin
      pv = o_valid; pidx = o_idx; pdata = o_data;
      if (stop_idx >= 0 && pv && int'(pidx) == stop_idx) begin
        ready = 1'b0;
        tick();
        chk("stop_valid", o_valid, 1);
        chk("stop_idx", o_idx, stop_idx);
        stopped = 1'b1;
        return;
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
      if (mode == 0 && cyc == 1) begin
        chk("first_valid", o_valid, 1);
        chk("first_idx", o_idx, first);
      end
      chk("dump_hold", o_hold, 1);
      if (pv && ready) begin
        if (got < n) begin
          chk("word_idx", pidx, eidx[got]);
          chk("word_data", pdata, edata[got]);
        end else begin
          chk("extra_word", got, n - 1);
        end
        got++;
      end else if (pv) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_idx", o_idx, pidx);
        chk("stall_data", o_data, pdata);
      end
    end
    chk("done", o_done, 1);
    chk("word_count", got, n);
    chk("timeout_clear", o_timeout, 0);
    chk("end_valid", o_valid, 0);
    chk("end_hold", o_hold, 1);
    if (mode == 0) chk("latency", cyc, 2 * n + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit stopped;
    rst = 1'b1; ready = 1'b0; pc = '0; sel = 0;

    // basic dump, idx*0x11111111 pattern
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
    do_reset();
    run_to_match();
    run_dump(0, -1, stopped);

    // backpressure 1,0,0
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    run_to_match();
    run_dump(1, -1, stopped);

    // reset while word 7 is pending, then full restart
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    run_to_match();
    run_dump(2, 7, stopped);
    chk("stop_reached", 32'(stopped), 1);
    do_reset();
    run_to_match();
    run_dump(2, -1, stopped);

    // watchdog expiry with TIMEOUT_CYCLES=16
    sel = 1;
    do_reset();
    pc = 32'h10;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e < 16) begin
        chk("pre_to_timeout", o_timeout, 0);
        chk("pre_to_done", o_done, 0);
      end
    end
    chk("to_timeout", o_timeout, 1);
    chk("to_done", o_done, 1);
    chk("to_hold", o_hold, 1);
    chk("to_valid", o_valid, 0);
    pc = 32'h48;
    ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("to_sticky_valid", o_valid, 0);
      chk("to_sticky_timeout", o_timeout, 1);
    end

    // PC match on the same edge the watchdog would expire
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    pc = 32'h10;
    for (int e = 1; e <= 15; e++) tick();
    pc = 32'h48;
    tick();
    pc = '0;
    chk("sim_timeout", o_timeout, 0);
    run_dump(2, -1, stopped);

    // single register configuration
    sel = 2;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_reset();
    run_to_match();
    run_dump(0, -1, stopped);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
